// File: rtl/da_result_drain.sv
// Output stage of the DA FIR: rounds/saturates each final accumulated sum,
// queues it in a small FIFO and streams it out over valid/ready.
module da_result_drain #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sum_valid_i,
  input  logic [DATA_W-1:0]          sum_in_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [OUT_W-1:0]           m_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_err_o,
  output logic                       sat_flag_o,
  input  logic                       clr_status_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Round-half-up constant and saturation bounds at DATA_W+1 bits so the add never wraps.
  localparam logic signed [DATA_W:0] RND_C = $signed({{DATA_W{1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [DATA_W:0] MAX_C =
    $signed({{(DATA_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [DATA_W:0] MIN_C =
    $signed({{(DATA_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}});
  localparam logic [LVL_W-1:0] FULL_C = LVL_W'(DEPTH);

  logic signed [DATA_W:0] sum_ext;
  logic signed [DATA_W:0] rounded;
  logic signed [DATA_W:0] shifted;
  logic [OUT_W-1:0]       conv;
  logic                   conv_sat;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;
  logic             push;
  logic             pop;

  always_comb begin
    sum_ext  = $signed({sum_in_i[DATA_W-1], sum_in_i});
    rounded  = sum_ext + RND_C;
    shifted  = rounded >>> SHIFT;
    conv     = shifted[OUT_W-1:0];
    conv_sat = 1'b0;
    if (shifted > MAX_C) begin
      conv     = {1'b0, {(OUT_W - 1){1'b1}}};
      conv_sat = 1'b1;
    end else if (shifted < MIN_C) begin
      conv     = {1'b1, {(OUT_W - 1){1'b0}}};
      conv_sat = 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop      = (level_q != '0) && m_ready_i;
    push     = sum_valid_i && ((level_q != FULL_C) || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    ovf_d = (sum_valid_i && !push) | (ovf_q & ~clr_status_i);
    sat_d = (push && conv_sat)     | (sat_q & ~clr_status_i);
  end

  // The head register looks ahead so m_data is ready in the same cycle m_valid rises.
  always_comb begin
    if (level_d == '0) begin
      head_d = '0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = conv;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= conv;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  assign m_valid_o  = (level_q != '0);
  assign m_data_o   = head_q;
  assign level_o    = level_q;
  assign ovf_err_o  = ovf_q;
  assign sat_flag_o = sat_q;

endmodule

// File: tb/tb_da_result_drain.sv
// Directed self-checking bench for da_result_drain (OUT_W=16, SHIFT=15, DEPTH=4).
module tb_da_result_drain;

  logic        clk;
  logic        rst;
  logic        sumValid;
  logic [31:0] sumIn;
  logic        mValid;
  logic        mReady;
  logic [15:0] mData;
  logic [2:0]  level;
  logic        ovfErr;
  logic        satFlag;
  logic        clrStatus;

  int checkCount;
  int failCount;

  da_result_drain #(
    .DATA_W(32), .OUT_W(16), .SHIFT(15), .DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sum_valid_i  (sumValid),
    .sum_in_i     (sumIn),
    .m_valid_o    (mValid),
    .m_ready_i    (mReady),
    .m_data_o     (mData),
    .level_o      (level),
    .ovf_err_o    (ovfErr),
    .sat_flag_o   (satFlag),
    .clr_status_i (clrStatus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sum for exactly one clock edge.
  task automatic applyStimulus(input logic [31:0] value);
    sumIn    = value;
    sumValid = 1'b1;
    tick();
    sumValid = 1'b0;
  endtask

  logic [15:0] drainExp [4];

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    sumValid   = 1'b0;
    sumIn      = '0;
    mReady     = 1'b0;
    clrStatus  = 1'b0;
    repeat (3) tick();
    checkOutput("rst_valid", 32'(mValid), 32'd0);
    checkOutput("rst_data", 32'(mData), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_ovf", 32'(ovfErr), 32'd0);
    checkOutput("rst_sat", 32'(satFlag), 32'd0);
    rst = 1'b0;
    tick();

    // Rounding cases, drained immediately.
    mReady = 1'b1;
    applyStimulus(32'h0000_4000);
    checkOutput("r1_valid", 32'(mValid), 32'd1);
    checkOutput("r1_data", 32'(mData), 32'h0001);
    checkOutput("r1_sat", 32'(satFlag), 32'd0);
    tick();
    checkOutput("r1_drained", 32'(level), 32'd0);
    applyStimulus(32'h3FFF_8000);
    checkOutput("r2_data", 32'(mData), 32'h7FFF);
    tick();
    applyStimulus(32'hC000_0000);
    checkOutput("r3_data", 32'(mData), 32'h8000);
    tick();
    applyStimulus(32'hFFFF_C000);
    checkOutput("r4_data", 32'(mData), 32'h0000);
    checkOutput("r4_valid", 32'(mValid), 32'd1);
    tick();
    applyStimulus(32'hFFFF_8000);
    checkOutput("r5_data", 32'(mData), 32'hFFFF);
    tick();

    // Genuine saturation in both directions.
    applyStimulus(32'h4000_0000);
    checkOutput("satp_data", 32'(mData), 32'h7FFF);
    checkOutput("satp_flag", 32'(satFlag), 32'd1);
    tick();
    applyStimulus(32'h8000_0000);
    checkOutput("satn_data", 32'(mData), 32'h8000);
    tick();
    clrStatus = 1'b1;
    tick();
    clrStatus = 1'b0;
    checkOutput("clr_sat", 32'(satFlag), 32'd0);
    clrStatus = 1'b1;
    applyStimulus(32'h7FFF_FFFF);
    clrStatus = 1'b0;
    checkOutput("set_wins", 32'(satFlag), 32'd1);
    tick();
    clrStatus = 1'b1;
    tick();
    clrStatus = 1'b0;

    // Overflow: five pushes into a stalled four-entry FIFO.
    mReady = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      applyStimulus(32'(v) << 15);
    end
    checkOutput("full_level", 32'(level), 32'd4);
    checkOutput("full_ovf", 32'(ovfErr), 32'd1);
    checkOutput("full_sat", 32'(satFlag), 32'd0);
    tick();
    checkOutput("stall_data", 32'(mData), 32'h0001);
    checkOutput("stall_valid", 32'(mValid), 32'd1);
    clrStatus = 1'b1;
    tick();
    clrStatus = 1'b0;
    checkOutput("clr_ovf", 32'(ovfErr), 32'd0);

    // Full FIFO with push and pop together, then drain through the wrap.
    mReady = 1'b1;
    applyStimulus(32'(6) << 15);
    checkOutput("pp_level", 32'(level), 32'd4);
    checkOutput("pp_ovf", 32'(ovfErr), 32'd0);
    drainExp[0] = 16'd2;
    drainExp[1] = 16'd3;
    drainExp[2] = 16'd4;
    drainExp[3] = 16'd6;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d", i), 32'(mData), 32'(drainExp[i]));
      tick();
    end
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_valid", 32'(mValid), 32'd0);
    repeat (2) tick();
    checkOutput("empty_level", 32'(level), 32'd0);
    applyStimulus(32'(9) << 15);
    checkOutput("post_empty_data", 32'(mData), 32'h0009);
    tick();

    // Asynchronous reset in the middle of a stream.
    mReady = 1'b0;
    applyStimulus(32'(7) << 15);
    applyStimulus(32'h7FFF_FFFF);
    applyStimulus(32'(8) << 15);
    checkOutput("mid_level", 32'(level), 32'd3);
    checkOutput("mid_sat", 32'(satFlag), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_valid", 32'(mValid), 32'd0);
    checkOutput("async_level", 32'(level), 32'd0);
    checkOutput("async_sat", 32'(satFlag), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("after_rst_valid", 32'(mValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
